// File: rtl/load_store_unit_pkg.sv
// Shared types and funct3 decode for the load/store unit.
// Access size is taken from funct3[1:0]; reserved codes fall to word size.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    localparam logic [2:0] MEM_FUNCT3_B  = 3'b000;
    localparam logic [2:0] MEM_FUNCT3_H  = 3'b001;
    localparam logic [2:0] MEM_FUNCT3_W  = 3'b010;
    localparam logic [2:0] MEM_FUNCT3_BU = 3'b100;
    localparam logic [2:0] MEM_FUNCT3_HU = 3'b101;

    function automatic lsu_size_t lsu_size(input logic [2:0] f3);
        if (f3[1])
            return SZ_W;
        else if (f3[0])
            return SZ_H;
        else
            return SZ_B;
    endfunction

    function automatic logic lsu_misaligned(
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic bad;
        bad = 1'b0;
        unique case (lsu_size(f3))
            SZ_H:    bad = lo[0];
            SZ_W:    bad = |lo;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: store enables/replication and load extract/extend.
// Pure combinational; shared by the store and load paths of the LSU.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  byte_enable,
    output logic [31:0] write_data,
    output logic [31:0] load_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        sext;

    assign rd_byte = read_data[{addr_lo, 3'b000} +: 8];
    assign rd_half = read_data[{addr_lo[1], 4'b0000} +: 16];
    assign sext    = ~funct3[2];

    always_comb begin
        byte_enable = 4'b1111;
        write_data  = store_data;
        load_data   = read_data;
        unique case (lsu_size(funct3))
            SZ_B: begin
                byte_enable = 4'b0001 << addr_lo;
                write_data  = {4{store_data[7:0]}};
                load_data   = {{24{sext & rd_byte[7]}}, rd_byte};
            end
            SZ_H: begin
                byte_enable = 4'b0011 << {addr_lo[1], 1'b0};
                write_data  = {2{store_data[15:0]}};
                load_data   = {{16{sext & rd_half[15]}}, rd_half};
            end
            default: begin
                byte_enable = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle data-memory stage: IDLE -> ACCESS -> DONE, stalls the core.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned accesses instead of aligning.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        misaligned,
    output logic [31:0] bus_address,
    output logic        bus_read_enable,
    output logic        bus_write_enable,
    output logic [3:0]  bus_byte_enable,
    output logic [31:0] bus_write_data,
    input  logic [31:0] bus_read_data,
    input  logic        bus_ready
);

    lsu_state_t  state;
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;
    logic        mis_q;
    logic        req;
    logic        mis_in;
    logic [1:0]  la_addr;
    logic [2:0]  la_funct3;
    logic [3:0]  la_be;
    logic [31:0] la_wd;
    logic [31:0] la_ld;

    assign req        = read_enable | write_enable;
    assign misaligned = mis_q;

    // Store lanes come from live inputs in IDLE, load lanes from latched ones.
    assign la_addr   = (state == IDLE) ? address[1:0] : addr_lo_q;
    assign la_funct3 = (state == IDLE) ? funct3 : funct3_q;

    lsu_lane_align u_lane_align (
        .funct3      (la_funct3),
        .addr_lo     (la_addr),
        .store_data  (store_data),
        .read_data   (bus_read_data),
        .byte_enable (la_be),
        .write_data  (la_wd),
        .load_data   (la_ld)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_in = lsu_misaligned(funct3, address[1:0]);
`else
    assign mis_in = 1'b0;
`endif

    always_comb begin
        stall = 1'b0;
        unique case (state)
            IDLE:    stall = reset & req;
            ACCESS:  stall = 1'b1;
            DONE:    stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            addr_lo_q        <= 2'b00;
            funct3_q         <= 3'b000;
            mis_q            <= 1'b0;
            load_data        <= 32'h0;
            bus_address      <= 32'h0;
            bus_read_enable  <= 1'b0;
            bus_write_enable <= 1'b0;
            bus_byte_enable  <= 4'h0;
            bus_write_data   <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        addr_lo_q <= address[1:0];
                        funct3_q  <= funct3;
                        if (mis_in) begin
                            state <= DONE;
                            mis_q <= 1'b1;
                        end else begin
                            state            <= ACCESS;
                            bus_address      <= {address[31:2], 2'b00};
                            bus_write_enable <= write_enable;
                            bus_read_enable  <= ~write_enable;
                            bus_byte_enable  <= write_enable ? la_be : 4'b1111;
                            bus_write_data   <= la_wd;
                        end
                    end
                end
                ACCESS: begin
                    if (bus_ready) begin
                        if (bus_read_enable)
                            load_data <= la_ld;
                        bus_read_enable  <= 1'b0;
                        bus_write_enable <= 1'b0;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    mis_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a wait-state bus responder.
// Build with LSU_MISALIGN_TRAP_EN to check the trap variant.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clock;
    logic        reset;
    logic        read_enable;
    logic        write_enable;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        stall;
    logic        misaligned;
    logic [31:0] bus_address;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [3:0]  bus_byte_enable;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;
    logic        bus_ready;

    typedef struct {
        logic        bus;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] ld;
        int          stalls;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    load_store_unit dut (
        .clock            (clock),
        .reset            (reset),
        .read_enable      (read_enable),
        .write_enable     (write_enable),
        .funct3           (funct3),
        .address          (address),
        .store_data       (store_data),
        .load_data        (load_data),
        .stall            (stall),
        .misaligned       (misaligned),
        .bus_address      (bus_address),
        .bus_read_enable  (bus_read_enable),
        .bus_write_enable (bus_write_enable),
        .bus_byte_enable  (bus_byte_enable),
        .bus_write_data   (bus_write_data),
        .bus_read_data    (bus_read_data),
        .bus_ready        (bus_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic we, input logic re,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd,
                          input int waits, input exp_t e);
        exp_t        x;
        int          cyc;
        int          stalls;
        int          w;
        logic        done;
        logic        seen;
        logic        o_we;
        logic        o_re;
        logic [31:0] o_addr;
        logic [31:0] o_wd;
        logic [3:0]  o_be;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        write_enable  = we;
        read_enable   = re;
        funct3        = f3;
        address       = a;
        store_data    = sd;
        bus_read_data = rd;
        bus_ready     = 1'b0;
        cyc = 0; stalls = 0; w = 0;
        done = 1'b0; seen = 1'b0; o_we = 1'b0; o_re = 1'b0;
        o_addr = '0; o_wd = '0; o_be = '0;
        while (!done && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (stall) begin
                stalls++;
                if (bus_read_enable | bus_write_enable) begin
                    if (!seen) begin
                        seen   = 1'b1;
                        o_addr = bus_address;
                        o_be   = bus_byte_enable;
                        o_wd   = bus_write_data;
                    end
                    o_we      = o_we | bus_write_enable;
                    o_re      = o_re | bus_read_enable;
                    bus_ready = (w == waits);
                    w++;
                end
            end else begin
                done      = 1'b1;
                bus_ready = 1'b0;
            end
        end
        check("done_in_budget", 32'(done), 32'd1);
        x = sb_q.pop_front();
        check("stall_cycles", 32'(stalls), 32'(x.stalls));
        check("bus_request", 32'(seen), 32'(x.bus));
        check("bus_write_enable", 32'(o_we), 32'(x.we));
        check("bus_read_enable", 32'(o_re), 32'(x.re));
        if (x.bus) begin
            check("bus_address", o_addr, x.addr);
            check("bus_byte_enable", 32'(o_be), 32'(x.be));
            if (x.we)
                check("bus_write_data", o_wd, x.wd);
        end
        check("load_data", load_data, x.ld);
        check("misaligned", 32'(misaligned), 32'(x.mis));
        @(posedge clock);
        #1;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        @(negedge clock);
        check("idle_stall", 32'(stall), 32'd0);
        check("misaligned_clear", 32'(misaligned), 32'd0);
        check("load_hold", load_data, x.ld);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset         = 1'b0;
        read_enable   = 1'b1;
        write_enable  = 1'b0;
        funct3        = MEM_FUNCT3_W;
        address       = 32'h0;
        store_data    = 32'h0;
        bus_read_data = 32'h0;
        bus_ready     = 1'b0;

        repeat (2) @(negedge clock);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_bus_re", 32'(bus_read_enable), 32'd0);
        check("rst_bus_we", 32'(bus_write_enable), 32'd0);
        check("rst_bus_be", 32'(bus_byte_enable), 32'd0);
        check("rst_bus_addr", bus_address, 32'd0);
        check("rst_bus_wd", bus_write_data, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        read_enable = 1'b0;
        reset       = 1'b1;
        @(negedge clock);
        check("nonmem_stall", 32'(stall), 32'd0);

        run_op(1'b1, 1'b0, MEM_FUNCT3_W, 32'h100, 32'hDEADBEEF, 32'h0, 0,
               '{1'b1, 1'b1, 1'b0, 32'h100, 4'b1111, 32'hDEADBEEF,
                 32'h0, 2, 1'b0});
        run_op(1'b0, 1'b1, MEM_FUNCT3_B, 32'h203, 32'h0, 32'h80FF1234, 3,
               '{1'b1, 1'b0, 1'b1, 32'h200, 4'b1111, 32'h0,
                 32'hFFFFFF80, 5, 1'b0});
        run_op(1'b0, 1'b1, MEM_FUNCT3_HU, 32'h202, 32'h0, 32'h80010000, 0,
               '{1'b1, 1'b0, 1'b1, 32'h200, 4'b1111, 32'h0,
                 32'h00008001, 2, 1'b0});
        run_op(1'b1, 1'b0, MEM_FUNCT3_B, 32'h1, 32'h000000AB, 32'h0, 0,
               '{1'b1, 1'b1, 1'b0, 32'h0, 4'b0010, 32'hABABABAB,
                 32'h00008001, 2, 1'b0});
        run_op(1'b1, 1'b1, MEM_FUNCT3_W, 32'h10, 32'h12345678, 32'h0, 1,
               '{1'b1, 1'b1, 1'b0, 32'h10, 4'b1111, 32'h12345678,
                 32'h00008001, 3, 1'b0});
        run_op(1'b0, 1'b1, MEM_FUNCT3_H, 32'h102, 32'h0, 32'hF00D0000, 1,
               '{1'b1, 1'b0, 1'b1, 32'h100, 4'b1111, 32'h0,
                 32'hFFFFF00D, 3, 1'b0});
        run_op(1'b0, 1'b1, MEM_FUNCT3_BU, 32'h101, 32'h0, 32'h0000A500, 2,
               '{1'b1, 1'b0, 1'b1, 32'h100, 4'b1111, 32'h0,
                 32'h000000A5, 4, 1'b0});
        run_op(1'b1, 1'b0, MEM_FUNCT3_H, 32'h106, 32'h0000BEEF, 32'h0, 0,
               '{1'b1, 1'b1, 1'b0, 32'h104, 4'b1100, 32'hBEEFBEEF,
                 32'h000000A5, 2, 1'b0});
        run_op(1'b0, 1'b1, MEM_FUNCT3_W, 32'h108, 32'h0, 32'hCAFEF00D, 0,
               '{1'b1, 1'b0, 1'b1, 32'h108, 4'b1111, 32'h0,
                 32'hCAFEF00D, 2, 1'b0});
        run_op(1'b0, 1'b1, 3'b011, 32'h10C, 32'h0, 32'h0BADBEEF, 0,
               '{1'b1, 1'b0, 1'b1, 32'h10C, 4'b1111, 32'h0,
                 32'h0BADBEEF, 2, 1'b0});

        // Abandon a load mid-ACCESS with an asynchronous reset.
        @(posedge clock);
        #1;
        read_enable = 1'b1;
        funct3      = MEM_FUNCT3_W;
        address     = 32'h20;
        bus_ready   = 1'b0;
        @(negedge clock);
        check("abort_idle_stall", 32'(stall), 32'd1);
        @(negedge clock);
        check("abort_access_re", 32'(bus_read_enable), 32'd1);
        #1;
        reset       = 1'b0;
        read_enable = 1'b0;
        #1;
        check("abort_bus_re", 32'(bus_read_enable), 32'd0);
        check("abort_bus_we", 32'(bus_write_enable), 32'd0);
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_load_data", load_data, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_idle", 32'(stall), 32'd0);

        run_op(1'b0, 1'b1, MEM_FUNCT3_W, 32'h20, 32'h0, 32'h55AA55AA, 1,
               '{1'b1, 1'b0, 1'b1, 32'h20, 4'b1111, 32'h0,
                 32'h55AA55AA, 3, 1'b0});

`ifdef LSU_MISALIGN_TRAP_EN
        run_op(1'b0, 1'b1, MEM_FUNCT3_W, 32'h102, 32'h0, 32'h11223344, 0,
               '{1'b0, 1'b0, 1'b0, 32'h0, 4'b0000, 32'h0,
                 32'h55AA55AA, 1, 1'b1});
`else
        run_op(1'b0, 1'b1, MEM_FUNCT3_W, 32'h102, 32'h0, 32'h11223344, 0,
               '{1'b1, 1'b0, 1'b1, 32'h100, 4'b1111, 32'h0,
                 32'h11223344, 2, 1'b0});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multicycle data-memory access stage sitting directly downstream of the single-cycle control decoder. It consumes `data_mem_read_enable` / `data_mem_write_enable` together with the ALU-computed address, funct3 and rs2 data. It runs a request/ready transaction on the data bus and stalls the core until the access completes. It then presents sign/zero-extended load data to the writeback mux (`CTL_WRITEBACK_DATA` path).

## Interface
- No parameters; XLEN fixed at 32.
- `clock`  in  1  core clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `read_enable`  in  1  from control `data_mem_read_enable`.
- `write_enable`  in  1  from control `data_mem_write_enable`.
- `funct3`  in  3  inst[14:12]; access size/signedness.
- `address`  in  32  ALU result (rs1 + imm).
- `store_data`  in  32  rs2 value.
- `load_data`  out  32  extended load result; valid while `stall`=0 in DONE.
- `stall`  out  1  core must hold PC and suppress regfile write while high.
- `misaligned`  out  1  misaligned-access flag (see Configuration).
- `bus_address`  out  32  word-aligned address ({addr[31:2],2'b00}).
- `bus_read_enable`  out  1  registered read request.
- `bus_write_enable`  out  1  registered write request.
- `bus_byte_enable`  out  4  byte lanes for writes.
- `bus_write_data`  out  32  lane-replicated store data.
- `bus_read_data`  in  32  read data; sampled when `bus_ready`=1.
- `bus_ready`  in  1  memory completes current request.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: a request (`read_enable|write_enable`) latches address, funct3, store_data and drives `stall`=1 combinationally. The FSM moves to ACCESS, and bus enables assert from the next cycle.
- Write takes priority if both enables are high: a write is performed and no read.
- ACCESS: `stall`=1. Bus outputs stay stable until `bus_ready`=1. On that edge, `bus_read_data` is extended into the `load_data` register and the FSM moves to DONE. Bus enables drop in the same edge.
- DONE: `stall`=0 for one cycle; the core commits and the next instruction is fetched. The FSM returns to IDLE unconditionally. Request inputs are ignored in DONE, because the same instruction is still presented.
- Store byte enables:
  - SB: 4'b0001<<addr[1:0], data {4{rs2[7:0]}}.
  - SH: 4'b0011<<{addr[1],1'b0}, data {2{rs2[15:0]}}.
  - SW: 4'b1111.
- Loads: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LW is the whole word. LB/LH sign-extend; LBU/LHU zero-extend.
- Reserved funct3 (011, 110, 111) behave as LW/SW.
- Reads always drive `bus_byte_enable`=4'b1111.
- Reset values (asynchronous): state IDLE, all bus enables 0, `bus_byte_enable` 0, `bus_address` 0, `bus_write_data` 0, `load_data` 0, `misaligned` 0.
- Because `stall` is combinational, its value during reset is 0, since inputs are ignored.
- Reset during ACCESS abandons the transaction; the bus must tolerate the dropped request.

## Timing
- Minimum latency per memory instruction is 3 cycles: IDLE (stall) → ACCESS with `bus_ready` → DONE (commit).
- Each extra wait cycle of `bus_ready`=0 adds one cycle.
- Non-memory instructions: zero added latency, `stall`=0.
- `bus_*` outputs are registered. `stall` is combinational from `read_enable|write_enable` in IDLE, and from state otherwise.
- `load_data` stays stable from the DONE cycle until the next completed load.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are detected: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - A misaligned access goes IDLE→DONE with no bus request, and `misaligned`=1 for the DONE cycle only.
  - For a misaligned load, `load_data` is left unchanged.
- Not defined:
  - `misaligned` is tied 0.
  - Halfwords ignore addr[0]; words ignore addr[1:0] (forced aligned).

## Structure
- Shared package:
  - `lsu_state_t` enum (IDLE/ACCESS/DONE).
  - funct3 constants `MEM_FUNCT3_B/H/W/BU/HU`.
- Sub-module `lsu_lane_align`: pure combinational byte-enable generation, store replication and load extract/extend. It is shared between the store path and the load path.

## Test plan
- SW addr 0x100, rs2 0xDEADBEEF, `bus_ready` on first ACCESS cycle → bus_address 0x100, byte_enable 4'b1111, write_data 0xDEADBEEF, `stall` high exactly 2 cycles.
- LB addr 0x203, `bus_read_data` 0x80FF_1234, 3 wait cycles → `load_data` 0xFFFFFF80, `stall` high 5 cycles.
- LHU addr 0x202, `bus_read_data` 0x8001_0000 → `load_data` 0x00008001. SB addr 0x1 rs2 0xAB → byte_enable 4'b0010, write_data 0xABABABAB.
- Both enables high (SW addr 0x10) → only `bus_write_enable` asserts, `bus_read_enable` stays 0.
- `reset` low while in ACCESS → bus enables 0 immediately, FSM IDLE, `load_data` 0. After release, a new LW completes normally.
- With `LSU_MISALIGN_TRAP_EN`: LW addr 0x102 → no bus enable, `misaligned`=1 one cycle, `stall` high 1 cycle. Without the macro, the same stimulus → bus_address 0x100 read.
